// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a two-flop input synchronizer and a
// mid-bit sampling FSM. CLK sets the number of clock cycles per bit period.
// Optional even-parity support is compiled in with `define UART_RX_PARITY_EN.
// Without that macro there is no PARITY_BIT state and PARITY_ERR is tied to 0.
module uart_rx #(
  parameter int CLK = 87
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       RX_SERIAL,
  output logic [7:0] RX_PARALLEL,
  output logic       RX_VALID,
  output logic       FRAME_ERR,
  output logic       PARITY_ERR,
  output logic       BUSY
);

  // Last count of a full bit period, and the count of the start-bit mid-point.
  localparam logic [15:0] CNT_LAST = 16'(CLK - 1);
  localparam logic [15:0] CNT_HALF = 16'((CLK - 1) / 2);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } state_t;

  state_t      state_r;
  logic [15:0] cnt_r;
  logic [2:0]  idx_r;
  logic [7:0]  shift_r;
  logic [7:0]  data_r;
  logic        valid_r;
  logic        ferr_r;
  logic        busy_r;
  logic        sync1_r;
  logic        sync2_r;
  logic        rx_sync_s;

`ifdef UART_RX_PARITY_EN
  logic        par_bit_r;
  logic        perr_r;

  // Even parity holds when the data bits and the parity bit XOR to zero.
  function automatic logic even_parity_ok(input logic [7:0] data, input logic par);
    return ~(^{data, par});
  endfunction
`endif

  assign rx_sync_s   = sync2_r;
  assign RX_PARALLEL = data_r;
  assign RX_VALID    = valid_r;
  assign FRAME_ERR   = ferr_r;
  assign BUSY        = busy_r;
`ifdef UART_RX_PARITY_EN
  assign PARITY_ERR  = perr_r;
`else
  assign PARITY_ERR  = 1'b0;
`endif

  // Two-flop synchronizer; both flops reset to the idle (high) line level.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= RX_SERIAL;
      sync2_r <= sync1_r;
    end
  end

  // Receive FSM: start detection, mid-bit data sampling, stop check, break wait.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 16'd0;
      idx_r     <= 3'd0;
      shift_r   <= 8'h00;
      data_r    <= 8'h00;
      valid_r   <= 1'b0;
      ferr_r    <= 1'b0;
      busy_r    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_r <= 1'b0;
      perr_r    <= 1'b0;
`endif
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      valid_r <= 1'b0;
      ferr_r  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_r  <= 1'b0;
`endif
      case (state_r)
        ST_IDLE: begin
          cnt_r <= 16'd0;
          idx_r <= 3'd0;
          if (rx_sync_s == 1'b0) begin
            state_r <= ST_START;
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end

        ST_START: begin
          if (cnt_r == CNT_HALF) begin
            cnt_r <= 16'd0;
            // Still low at mid-bit: a real start bit and the sampling reference.
            if (rx_sync_s == 1'b0) begin
              state_r <= ST_DATA;
            end else begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end

        ST_DATA: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r          <= 16'd0;
            shift_r[idx_r] <= rx_sync_s;
            if (idx_r == 3'd7) begin
              idx_r <= 3'd0;
`ifdef UART_RX_PARITY_EN
              state_r <= ST_PARITY;
`else
              state_r <= ST_STOP;
`endif
            end else begin
              idx_r <= idx_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r     <= 16'd0;
            par_bit_r <= rx_sync_s;
            state_r   <= ST_STOP;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
`endif

        ST_STOP: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r <= 16'd0;
            if (rx_sync_s == 1'b1) begin
              // Good frame: publish the byte and go straight back to IDLE so a
              // start edge right after the stop bit is still caught.
              data_r  <= shift_r;
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
`ifdef UART_RX_PARITY_EN
              if (even_parity_ok(shift_r, par_bit_r)) begin
                valid_r <= 1'b1;
              end else begin
                perr_r  <= 1'b1;
              end
`else
              valid_r <= 1'b1;
`endif
            end else begin
              // Framing error wins over parity; the held byte is left alone.
              ferr_r  <= 1'b1;
              state_r <= ST_BREAK;
            end
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end

        ST_BREAK: begin
          // Hold off until the line returns high so a break is not a start bit.
          if (rx_sync_s == 1'b1) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            busy_r  <= 1'b1;
          end
        end

        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= 16'd0;
          idx_r   <= 3'd0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx with CLK=8.
// Frames are driven bit by bit on the falling clock edge; a monitor on the
// falling edge counts strobes and logs received bytes. Build with
// UART_RX_PARITY_EN defined to also exercise the parity tests.
module tb_uart_rx;

  localparam int CLK_T = 8;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  // 2 sync cycles + 1 IDLE decision + (H+1) to mid start + 9 (10 with parity)
  // bit periods to the stop sample; RX_VALID is seen on the following half cycle.
  localparam int LAT = 3 + ((CLK_T - 1) / 2 + 1) + (9 + PAR_BITS) * CLK_T;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic       RX_SERIAL = 1'b1;
  logic [7:0] RX_PARALLEL;
  logic       RX_VALID;
  logic       FRAME_ERR;
  logic       PARITY_ERR;
  logic       BUSY;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  int overlap_cnt = 0;
  int long_cnt = 0;
  int last_valid_cyc = 0;
  int start_cyc = 0;
  int base_v, base_f, base_p, base_q;
  logic prev_v = 1'b0;
  logic prev_f = 1'b0;
  logic prev_p = 1'b0;
  logic [7:0] got_q[$];
`ifdef UART_RX_PARITY_EN
  logic bad_par = 1'b0;
`endif

  uart_rx #(.CLK(CLK_T)) dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .RX_SERIAL  (RX_SERIAL),
    .RX_PARALLEL(RX_PARALLEL),
    .RX_VALID   (RX_VALID),
    .FRAME_ERR  (FRAME_ERR),
    .PARITY_ERR (PARITY_ERR),
    .BUSY       (BUSY)
  );

  always #5 CLOCK = ~CLOCK;

  always @(posedge CLOCK) cyc <= cyc + 1;

  // Strobe monitor, sampled away from the active edge.
  always @(negedge CLOCK) begin
    if (RX_VALID === 1'b1) begin
      valid_cnt++;
      got_q.push_back(RX_PARALLEL);
      last_valid_cyc = cyc;
    end
    if (FRAME_ERR === 1'b1) ferr_cnt++;
    if (PARITY_ERR === 1'b1) perr_cnt++;
    if ((int'(RX_VALID === 1'b1) + int'(FRAME_ERR === 1'b1) + int'(PARITY_ERR === 1'b1)) > 1)
      overlap_cnt++;
    if ((RX_VALID === 1'b1 && prev_v) || (FRAME_ERR === 1'b1 && prev_f) ||
        (PARITY_ERR === 1'b1 && prev_p))
      long_cnt++;
    prev_v = (RX_VALID === 1'b1);
    prev_f = (FRAME_ERR === 1'b1);
    prev_p = (PARITY_ERR === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] got_at(input int i);
    if (i < got_q.size()) return {24'h0, got_q[i]};
    return 32'hDEAD_BEEF;
  endfunction

  task automatic drive_bit(input logic b);
    RX_SERIAL = b;
    repeat (CLK_T) @(negedge CLOCK);
  endtask

  task automatic idle(input int n);
    RX_SERIAL = 1'b1;
    repeat (n) @(negedge CLOCK);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ bad_par);
`endif
    drive_bit(stop_b);
  endtask

  task automatic snap();
    base_v = valid_cnt;
    base_f = ferr_cnt;
    base_p = perr_cnt;
    base_q = got_q.size();
  endtask

  initial begin
    // Reset state
    RESET = 1'b1;
    RX_SERIAL = 1'b1;
    repeat (3) @(negedge CLOCK);
    chk("rst_data",  {24'h0, RX_PARALLEL}, 32'h00);
    chk("rst_valid", {31'h0, RX_VALID},    32'h0);
    chk("rst_ferr",  {31'h0, FRAME_ERR},   32'h0);
    chk("rst_perr",  {31'h0, PARITY_ERR},  32'h0);
    chk("rst_busy",  {31'h0, BUSY},        32'h0);
    RESET = 1'b0;
    idle(2 * CLK_T);

    // Single frame 0xA5
    snap();
    send_frame(8'hA5, 1'b1);
    idle(2 * CLK_T);
    chk("a5_valid_cnt", valid_cnt - base_v, 32'd1);
    chk("a5_data",      got_at(base_q),     32'hA5);
    chk("a5_latency",   last_valid_cyc - start_cyc, LAT);
    chk("a5_busy",      {31'h0, BUSY},      32'h0);
    chk("a5_ferr",      ferr_cnt - base_f,  32'd0);
    chk("a5_perr",      perr_cnt - base_p,  32'd0);

    // Back-to-back frames, no gap between stop and next start
    snap();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    idle(2 * CLK_T);
    chk("b2b_valid_cnt", valid_cnt - base_v,  32'd3);
    chk("b2b_data0",     got_at(base_q),      32'h00);
    chk("b2b_data1",     got_at(base_q + 1),  32'hFF);
    chk("b2b_data2",     got_at(base_q + 2),  32'h3C);
    chk("b2b_ferr",      ferr_cnt - base_f,   32'd0);

    // Two-cycle glitch: BUSY rises, start check rejects it
    snap();
    RX_SERIAL = 1'b0;
    repeat (2) @(negedge CLOCK);
    RX_SERIAL = 1'b1;
    repeat (2) @(negedge CLOCK);
    chk("glitch_busy_hi", {31'h0, BUSY}, 32'h1);
    repeat (10) @(negedge CLOCK);
    chk("glitch_busy_lo", {31'h0, BUSY},     32'h0);
    chk("glitch_valid",   valid_cnt - base_v, 32'd0);
    chk("glitch_ferr",    ferr_cnt - base_f,  32'd0);

    // Bad stop bit with the line held low 30 cycles, then a good frame
    snap();
    send_frame(8'h5A, 1'b0);
    repeat (30 - CLK_T) @(negedge CLOCK);
    chk("brk_ferr_cnt", ferr_cnt - base_f,        32'd1);
    chk("brk_valid",    valid_cnt - base_v,       32'd0);
    chk("brk_data",     {24'h0, RX_PARALLEL},     32'h3C);
    chk("brk_busy_hi",  {31'h0, BUSY},            32'h1);
    idle(CLK_T);
    chk("brk_busy_lo",  {31'h0, BUSY},            32'h0);
    snap();
    send_frame(8'h11, 1'b1);
    idle(2 * CLK_T);
    chk("brk_next_cnt",  valid_cnt - base_v, 32'd1);
    chk("brk_next_data", got_at(base_q),     32'h11);

    // Reset during data bit 4, then a clean 0x81 frame
    snap();
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    RX_SERIAL = 1'b1;
    repeat (CLK_T / 2) @(negedge CLOCK);
    RESET = 1'b1;
    @(negedge CLOCK);
    RESET = 1'b0;
    chk("mrst_data",  {24'h0, RX_PARALLEL}, 32'h00);
    chk("mrst_valid", {31'h0, RX_VALID},    32'h0);
    chk("mrst_ferr",  {31'h0, FRAME_ERR},   32'h0);
    chk("mrst_perr",  {31'h0, PARITY_ERR},  32'h0);
    chk("mrst_busy",  {31'h0, BUSY},        32'h0);
    idle(12 * CLK_T);
    chk("mrst_no_valid", valid_cnt - base_v, 32'd0);
    chk("mrst_no_ferr",  ferr_cnt - base_f,  32'd0);
    snap();
    send_frame(8'h81, 1'b1);
    idle(2 * CLK_T);
    chk("mrst_81_cnt",  valid_cnt - base_v, 32'd1);
    chk("mrst_81_data", got_at(base_q),     32'h81);

`ifdef UART_RX_PARITY_EN
    // Bad parity: byte still published, PARITY_ERR instead of RX_VALID
    snap();
    bad_par = 1'b1;
    send_frame(8'h03, 1'b1);
    bad_par = 1'b0;
    idle(2 * CLK_T);
    chk("par_bad_perr",  perr_cnt - base_p,    32'd1);
    chk("par_bad_valid", valid_cnt - base_v,   32'd0);
    chk("par_bad_data",  {24'h0, RX_PARALLEL}, 32'h03);
    // Good parity (bit 0 for 0x03)
    snap();
    send_frame(8'h03, 1'b1);
    idle(2 * CLK_T);
    chk("par_ok_valid", valid_cnt - base_v, 32'd1);
    chk("par_ok_perr",  perr_cnt - base_p,  32'd0);
    chk("par_ok_data",  got_at(base_q),     32'h03);
`else
    chk("perr_never", perr_cnt, 32'd0);
`endif

    // Strobe hygiene over the whole run
    chk("strobe_overlap", overlap_cnt, 32'd0);
    chk("strobe_long",    long_cnt,    32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial-to-parallel UART receiver: 8 data bits, LSB first, 1 start bit, 1 stop bit, no parity by default.
- Sits on the receive side of the serial link, opposite `uart_tx`.
- Converts `RX_SERIAL` into a byte on `RX_PARALLEL` with a one-cycle `RX_VALID` strobe.
- Uses the same clocks-per-bit convention as `uart_tx`, so a `uart_tx` and a `uart_rx` with equal `CLK` interoperate directly.

Parameters:
- `CLK`, default 87: clock cycles per bit period; legal range 4..65535.

Ports:
- `CLOCK` — input, 1 — system clock; all logic on the rising edge.
- `RESET` — input, 1 — synchronous, active-high reset.
- `RX_SERIAL` — input, 1 — asynchronous serial line; idles high.
- `RX_PARALLEL` — output, 8 — last correctly framed byte.
- `RX_VALID` — output, 1 — one-cycle pulse: new byte on `RX_PARALLEL`.
- `FRAME_ERR` — output, 1 — one-cycle pulse: stop bit sampled low.
- `PARITY_ERR` — output, 1 — one-cycle pulse: parity mismatch (tied 0 unless the optional feature is compiled in).
- `BUSY` — output, 1 — high whenever the state is not IDLE.

Behaviour:
- Reset: `RESET`=1 at a rising edge forces the following, regardless of state (mid-frame reset discards the partial byte):
  - State=IDLE, counter=0, bit index=0, shift register=0.
  - `RX_PARALLEL`=0x00; `RX_VALID`, `FRAME_ERR`, `PARITY_ERR`, `BUSY` all 0.
  - Both synchronizer flops=1.
- Input synchronizer:
  - `RX_SERIAL` passes through two flops to produce `RX_SYNC`, adding 2 cycles of latency.
  - All decisions use `RX_SYNC` only.
- Counter: 16-bit, counts 0..`CLK`-1. Let H=(`CLK`-1)/2, integer division.
- States:
  - IDLE: counter=0, index=0. If `RX_SYNC`==0 -> START_BIT.
  - START_BIT:
    - Counter increments until it equals H; at H, `RX_SYNC` is sampled.
    - If 0: counter=0 -> DATA_BITS. This sample point is the mid-bit reference.
    - If 1: glitch -> IDLE, no output pulse.
  - DATA_BITS:
    - Counter increments until it equals `CLK`-1; at `CLK`-1, shift register bit[index]=`RX_SYNC`, counter=0.
    - If index<7: index+1, stay. If index==7: index=0 -> STOP_BIT (or PARITY_BIT when the feature is compiled in).
  - STOP_BIT: at counter==`CLK`-1, sample `RX_SYNC`.
    - If 1: `RX_PARALLEL`=shift register and `RX_VALID`=1 for exactly the next cycle -> IDLE.
    - If 0: `FRAME_ERR`=1 for exactly one cycle, `RX_PARALLEL` unchanged -> BREAK_WAIT.
  - BREAK_WAIT: stay until `RX_SYNC`==1 -> IDLE. Prevents a held-low (break) line from being taken as a new start bit.
- Sample timing:
  - Data bit k (k=0..7) is sampled (k+1)·`CLK` cycles after the start-bit mid-sample.
  - The stop bit is sampled 9·`CLK` cycles after the start-bit mid-sample.
  - `RX_VALID` is asserted the cycle after the stop sample.
- Back-to-back frames:
  - After a good stop sample, IDLE is re-entered with roughly half a bit still remaining on the line.
  - A start edge arriving immediately after the stop bit must be caught; there is no dead time beyond that one cycle.
- Output strobes: `RX_VALID`, `FRAME_ERR` and `PARITY_ERR` are never high simultaneously and are never held for more than 1 cycle.
- Flow control: none. Consumers must take `RX_PARALLEL` within one frame time; it holds until the next good frame.

Optional Feature:
- Macro: `UART_RX_PARITY_EN`.
- Defined:
  - An extra PARITY_BIT state is added between DATA_BITS and STOP_BIT, sampled at counter==`CLK`-1.
  - Even parity: the XOR of the 8 data bits and the parity bit must be 0.
  - On mismatch, the byte is still written to `RX_PARALLEL` at the stop sample, but `PARITY_ERR` pulses instead of `RX_VALID`.
  - If the stop bit is bad, `FRAME_ERR` takes precedence.
- Undefined: there is no PARITY_BIT state and `PARITY_ERR` is a constant 0.

Test Plan:
- `CLK`=8: drive frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> exactly one `RX_VALID` pulse, `RX_PARALLEL`=0xA5, `BUSY` back to 0, no error pulses.
- `uart_tx` (`CLK`=8) looped to `uart_rx` (`CLK`=8), send 0x00, 0xFF, 0x3C back-to-back -> three `RX_VALID` pulses, with data 0x00, 0xFF, 0x3C in order.
- Pull `RX_SERIAL` low for 2 cycles, then high -> `BUSY` rises then returns to 0 at the start check, no `RX_VALID`, no `FRAME_ERR`.
- Frame 0x5A followed by a stop bit of 0, with the line held low 30 cycles -> one `FRAME_ERR` pulse, `RX_PARALLEL` keeps its prior value, state stays BREAK_WAIT until the line goes high, then a following 0x11 frame is received correctly.
- Assert `RESET` for 1 cycle during data bit 4 of a frame, then send 0x81 -> all outputs 0 after reset, partial byte discarded, 0x81 received with one `RX_VALID`.
- With `UART_RX_PARITY_EN`: frame 0x03 with parity bit 0 -> `RX_VALID`; same frame with parity bit 1 -> `PARITY_ERR` pulse, `RX_PARALLEL`=0x03, no `RX_VALID`.
